gl1_pixel_split: RTL and testbench
==================================

GL1_PIXEL_SPLIT -- requirements
Module: gl1_pixel_split

Interface
REQ-001 Parameter D_WIDTH, default 8, pixel luma width in bits.
REQ-002 Parameter CNT_WIDTH, default 12, width of line-length counters (max line 2^CNT_WIDTH-1 pixels).
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 up_data/up_valid/up_tlast/up_tuser  input  D_WIDTH/1/1/1  source pixel stream; tlast = end of line, tuser = start of frame.
REQ-006 up_ready  output  1  source handshake; transfer when up_valid & up_ready.
REQ-007 down_data_x/down_valid_x/down_tlast_x/down_tuser_x  output  D_WIDTH/1/1/1  lane x in {a,b,c,d} stream.
REQ-008 down_ready_x  input  1  lane x sink handshake; transfer when down_valid_x & down_ready_x.
REQ-009 err_odd_width  output  1  sticky: a line ended on an even column.
REQ-010 err_len_mismatch  output  1  sticky: a line length differs from the frame's first line.

Function
REQ-011 Lane select = {row_odd, col_odd}: 00->a, 01->b, 10->c, 11->d; each input pixel goes to exactly one lane.
REQ-012 col_odd toggles on every accepted pixel; an accepted pixel with up_tlast sets col_odd=0 and toggles row_odd.
REQ-013 Accepted pixel with up_tuser is treated as row 0 col 0 (lane a) regardless of current parity; parity then advances per REQ-012 from that origin.
REQ-014 Each lane has a one-entry output register holding data, tlast, tuser; latency input-accept to down_valid_x = 1 cycle.
REQ-015 up_ready = ~rst_active & (~down_valid_sel | down_ready_sel), where sel is the lane REQ-011/REQ-013 would choose for the current up beat; combinational, no dependence on up_valid.
REQ-016 Lane register loads on accept, clears valid on drain; simultaneous drain and load on one lane keeps valid=1 with new contents, full throughput.
REQ-017 Lanes not selected are unaffected; a stalled lane blocks only when it is the selected lane.
REQ-018 down_tlast_x/down_tuser_x copy the input flags of the pixel held; no flag is synthesised.
REQ-019 Line counter counts accepted pixels per line; on tlast, first line of frame stores its length as ref_len, later lines compare; mismatch sets err_len_mismatch.
REQ-020 tlast accepted with col_odd=0 (line length odd) sets err_odd_width.
REQ-021 Both error flags clear on an accepted tuser pixel (that pixel's own checks apply after clearing) and on reset.
REQ-022 tuser and tlast on the same pixel: pixel to lane a, err_odd_width set, ref_len=1, row_odd=1 afterwards.
REQ-023 Line counter saturates at all-ones; saturated lines compare as mismatch.
REQ-024 Pairing of even-row (a,b) with odd-row (c,d) pixels is downstream's job; lanes a/b need downstream buffering >= line_width/2 pixels.

Reset
REQ-025 While rst=0: up_ready=0, all down_valid_x=0, down_data_x/tlast/tuser=0, col_odd=row_odd=0, counters/ref_len=0, first-line flag set, errors=0.
REQ-026 Reset asserted mid-line discards all lane contents; first post-reset pixel routes to lane a.

Structure
REQ-027 Package gl_video_pkg holds D_WIDTH/CNT_WIDTH defaults and lane enum LANE_A..LANE_D (2-bit).
REQ-028 One sub-module gl_lane_slice (one-entry register slice with load/drain), instantiated four times.

Verification
REQ-029 Frame 4x2, all readies high, tuser on pixel0: pixels 0..7 -> lanes a,b,a,b,c,d,c,d; tlast on pixel 3 in lane b, pixel 7 in lane d; no errors.
REQ-030 down_ready_a=0, stream a,b,a: second a-pixel stalls, up_ready=0 until down_ready_a=1; lane b output unaffected.
REQ-031 Line widths 4 then 6 -> err_len_mismatch=1 after second tlast; next tuser clears it.
REQ-032 Line width 3 -> err_odd_width=1; following pixel routes to lane c.
REQ-033 tuser mid-line (col_odd=1,row_odd=1) -> that pixel to lane a with down_tuser_a=1.
REQ-034 Reset asserted with all lanes full -> next cycle all down_valid_x=0, up_ready=0; after release first pixel on lane a.

Source files
------------

// File: rtl/gl1_pixel_split_pkg.sv
// Shared video defaults and lane encoding for the pixel splitter.
// A lane is selected by {row_odd, col_odd}; a start-of-frame pixel always goes to lane A.
package gl_video_pkg;

   localparam int D_WIDTH_DEF   = 8;
   localparam int CNT_WIDTH_DEF = 12;

   typedef enum logic [1:0] {
      LANE_A = 2'd0,
      LANE_B = 2'd1,
      LANE_C = 2'd2,
      LANE_D = 2'd3
   } lane_e;

   function automatic lane_e lane_sel(input logic tuser, input logic row_odd, input logic col_odd);
      return tuser ? LANE_A : lane_e'({row_odd, col_odd});
   endfunction

endpackage

// File: rtl/gl1_pixel_split_if.sv
// Source stream, four lane streams and sticky status for gl1_pixel_split.
// The master modport is the source/sink side; slave is the splitter itself.
interface gl1_pixel_split_if #(
   parameter int D_WIDTH = gl_video_pkg::D_WIDTH_DEF
) ();

   logic [D_WIDTH-1:0] up_data;
   logic               up_valid;
   logic               up_tlast;
   logic               up_tuser;
   logic               up_ready;

   logic [D_WIDTH-1:0] down_data_a, down_data_b, down_data_c, down_data_d;
   logic               down_valid_a, down_valid_b, down_valid_c, down_valid_d;
   logic               down_tlast_a, down_tlast_b, down_tlast_c, down_tlast_d;
   logic               down_tuser_a, down_tuser_b, down_tuser_c, down_tuser_d;
   logic               down_ready_a, down_ready_b, down_ready_c, down_ready_d;

   logic               err_odd_width;
   logic               err_len_mismatch;

   modport master (
      output up_data, up_valid, up_tlast, up_tuser,
      input  up_ready,
      input  down_data_a, down_data_b, down_data_c, down_data_d,
      input  down_valid_a, down_valid_b, down_valid_c, down_valid_d,
      input  down_tlast_a, down_tlast_b, down_tlast_c, down_tlast_d,
      input  down_tuser_a, down_tuser_b, down_tuser_c, down_tuser_d,
      output down_ready_a, down_ready_b, down_ready_c, down_ready_d,
      input  err_odd_width, err_len_mismatch
   );

   modport slave (
      input  up_data, up_valid, up_tlast, up_tuser,
      output up_ready,
      output down_data_a, down_data_b, down_data_c, down_data_d,
      output down_valid_a, down_valid_b, down_valid_c, down_valid_d,
      output down_tlast_a, down_tlast_b, down_tlast_c, down_tlast_d,
      output down_tuser_a, down_tuser_b, down_tuser_c, down_tuser_d,
      input  down_ready_a, down_ready_b, down_ready_c, down_ready_d,
      output err_odd_width, err_len_mismatch
   );

endinterface

// File: rtl/gl1_pixel_split_lane.sv
// One-entry register slice: loads a pixel with its flags, clears valid when drained.
// Load wins over drain so a same-cycle drain+load keeps full throughput.
module gl_lane_slice
   import gl_video_pkg::*;
#(
   parameter int D_WIDTH = D_WIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               drain,
   input  logic [D_WIDTH-1:0] din,
   input  logic               tlast_in,
   input  logic               tuser_in,
   output logic               valid,
   output logic [D_WIDTH-1:0] dout,
   output logic               tlast_out,
   output logic               tuser_out
);

   logic               valid_q, valid_d;
   logic [D_WIDTH-1:0] data_q, data_d;
   logic               tlast_q, tlast_d;
   logic               tuser_q, tuser_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      tlast_d = tlast_q;
      tuser_d = tuser_q;
      if (drain) begin
         valid_d = 1'b0;
      end
      if (load) begin
         valid_d = 1'b1;
         data_d  = din;
         tlast_d = tlast_in;
         tuser_d = tuser_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         tlast_q <= 1'b0;
         tuser_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         tlast_q <= tlast_d;
         tuser_q <= tuser_d;
      end
   end

   assign valid     = valid_q;
   assign dout      = data_q;
   assign tlast_out = tlast_q;
   assign tuser_out = tuser_q;

endmodule

// File: rtl/gl1_pixel_split.sv
// Splits a raster pixel stream into four lanes by row/column parity (a,b = even row; c,d = odd row)
// and flags odd line widths and line-length mismatches within a frame.
module gl1_pixel_split
   import gl_video_pkg::*;
#(
   parameter int D_WIDTH   = D_WIDTH_DEF,
   parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
   input logic              clk,
   input logic              rst,
   gl1_pixel_split_if.slave bus
);

   logic [3:0]         lane_valid, lane_ready, lane_load, lane_tlast, lane_tuser;
   logic [D_WIDTH-1:0] lane_data [4];

   lane_e sel;
   logic  up_ready;
   logic  accept;

   logic                 col_odd_q, col_odd_d;
   logic                 row_odd_q, row_odd_d;
   logic                 first_line_q, first_line_d;
   logic                 err_odd_q, err_odd_d;
   logic                 err_mis_q, err_mis_d;
   logic [CNT_WIDTH-1:0] line_cnt_q, line_cnt_d;
   logic [CNT_WIDTH-1:0] ref_len_q, ref_len_d;

   logic                 origin_row, origin_col, first_base, err_odd_base, err_mis_base;
   logic [CNT_WIDTH-1:0] cnt_base, line_len;

   assign lane_ready = {bus.down_ready_d, bus.down_ready_c, bus.down_ready_b, bus.down_ready_a};

   // Ready looks only at the lane this beat would target, never at up_valid.
   always_comb begin
      sel       = lane_sel(bus.up_tuser, row_odd_q, col_odd_q);
      up_ready  = rst & (~lane_valid[sel] | lane_ready[sel]);
      accept    = bus.up_valid & up_ready;
      lane_load = '0;
      lane_load[sel] = accept;
   end

   for (genvar i = 0; i < 4; i++) begin : g_lane
      gl_lane_slice #(.D_WIDTH(D_WIDTH)) u_lane (
         .clk       (clk),
         .rst       (rst),
         .load      (lane_load[i]),
         .drain     (lane_ready[i]),
         .din       (bus.up_data),
         .tlast_in  (bus.up_tlast),
         .tuser_in  (bus.up_tuser),
         .valid     (lane_valid[i]),
         .dout      (lane_data[i]),
         .tlast_out (lane_tlast[i]),
         .tuser_out (lane_tuser[i])
      );
   end

   // A tuser pixel restarts position, line count and errors before its own checks apply.
   always_comb begin
      origin_row   = bus.up_tuser ? 1'b0 : row_odd_q;
      origin_col   = bus.up_tuser ? 1'b0 : col_odd_q;
      first_base   = bus.up_tuser | first_line_q;
      err_odd_base = bus.up_tuser ? 1'b0 : err_odd_q;
      err_mis_base = bus.up_tuser ? 1'b0 : err_mis_q;
      cnt_base     = bus.up_tuser ? '0 : line_cnt_q;
      line_len     = (cnt_base == '1) ? cnt_base : cnt_base + 1'b1;

      col_odd_d    = col_odd_q;
      row_odd_d    = row_odd_q;
      first_line_d = first_line_q;
      err_odd_d    = err_odd_q;
      err_mis_d    = err_mis_q;
      line_cnt_d   = line_cnt_q;
      ref_len_d    = ref_len_q;

      if (accept) begin
         first_line_d = first_base;
         err_odd_d    = err_odd_base;
         err_mis_d    = err_mis_base;
         if (bus.up_tlast) begin
            col_odd_d  = 1'b0;
            row_odd_d  = ~origin_row;
            line_cnt_d = '0;
            if (!origin_col) begin
               err_odd_d = 1'b1;
            end
            if (first_base) begin
               ref_len_d    = line_len;
               first_line_d = 1'b0;
            end else if ((line_len != ref_len_q) || (line_len == '1)) begin
               err_mis_d = 1'b1;
            end
         end else begin
            col_odd_d  = ~origin_col;
            row_odd_d  = origin_row;
            line_cnt_d = line_len;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         col_odd_q    <= 1'b0;
         row_odd_q    <= 1'b0;
         first_line_q <= 1'b1;
         err_odd_q    <= 1'b0;
         err_mis_q    <= 1'b0;
         line_cnt_q   <= '0;
         ref_len_q    <= '0;
      end else begin
         col_odd_q    <= col_odd_d;
         row_odd_q    <= row_odd_d;
         first_line_q <= first_line_d;
         err_odd_q    <= err_odd_d;
         err_mis_q    <= err_mis_d;
         line_cnt_q   <= line_cnt_d;
         ref_len_q    <= ref_len_d;
      end
   end

   assign bus.up_ready         = up_ready;
   assign bus.err_odd_width    = err_odd_q;
   assign bus.err_len_mismatch = err_mis_q;

   assign bus.down_valid_a = lane_valid[0];
   assign bus.down_valid_b = lane_valid[1];
   assign bus.down_valid_c = lane_valid[2];
   assign bus.down_valid_d = lane_valid[3];
   assign bus.down_data_a  = lane_data[0];
   assign bus.down_data_b  = lane_data[1];
   assign bus.down_data_c  = lane_data[2];
   assign bus.down_data_d  = lane_data[3];
   assign bus.down_tlast_a = lane_tlast[0];
   assign bus.down_tlast_b = lane_tlast[1];
   assign bus.down_tlast_c = lane_tlast[2];
   assign bus.down_tlast_d = lane_tlast[3];
   assign bus.down_tuser_a = lane_tuser[0];
   assign bus.down_tuser_b = lane_tuser[1];
   assign bus.down_tuser_c = lane_tuser[2];
   assign bus.down_tuser_d = lane_tuser[3];

endmodule

// File: tb/tb_gl1_pixel_split.sv
// Bench for gl1_pixel_split: directed vector table, hand sequences and random traffic,
// all checked against a raster-position reference model with per-lane queues.
module tb_gl1_pixel_split;

   localparam int SAT = (1 << 12) - 1;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
      logic       u;
   } beat_t;

   typedef struct {
      logic [7:0] d;
      logic       l;
      logic       u;
      int         lane;
   } vec_t;

   logic clk;
   logic rst;

   gl1_pixel_split_if #(.D_WIDTH(8)) bus ();

   gl1_pixel_split #(.D_WIDTH(8), .CNT_WIDTH(12)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // reference model state
   beat_t mq [4][$];
   int    m_row, m_col, m_len, m_ref;
   bit    m_first, m_odd, m_mis, m_in_reset;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [10:0] lane_out(input int l);
      case (l)
         0:       return {bus.down_valid_a, bus.down_tuser_a, bus.down_tlast_a, bus.down_data_a};
         1:       return {bus.down_valid_b, bus.down_tuser_b, bus.down_tlast_b, bus.down_data_b};
         2:       return {bus.down_valid_c, bus.down_tuser_c, bus.down_tlast_c, bus.down_data_c};
         default: return {bus.down_valid_d, bus.down_tuser_d, bus.down_tlast_d, bus.down_data_d};
      endcase
   endfunction

   function automatic logic get_rdy(input int l);
      case (l)
         0:       return bus.down_ready_a;
         1:       return bus.down_ready_b;
         2:       return bus.down_ready_c;
         default: return bus.down_ready_d;
      endcase
   endfunction

   task automatic set_rdy(input logic [3:0] r);
      bus.down_ready_a = r[0];
      bus.down_ready_b = r[1];
      bus.down_ready_c = r[2];
      bus.down_ready_d = r[3];
   endtask

   task automatic model_reset();
      for (int l = 0; l < 4; l++) mq[l].delete();
      m_row = 0; m_col = 0; m_len = 0; m_ref = 0;
      m_first = 1'b1; m_odd = 1'b0; m_mis = 1'b0;
   endtask

   function automatic int model_sel();
      if (bus.up_tuser) return 0;
      return (m_row % 2) * 2 + (m_col % 2);
   endfunction

   task automatic model_accept();
      beat_t b;
      int    lane;
      if (bus.up_tuser) begin
         m_row = 0; m_col = 0; m_len = 0;
         m_first = 1'b1; m_odd = 1'b0; m_mis = 1'b0;
      end
      lane = (m_row % 2) * 2 + (m_col % 2);
      b.d = bus.up_data; b.l = bus.up_tlast; b.u = bus.up_tuser;
      mq[lane].push_back(b);
      if (m_len < SAT) m_len++;
      if (bus.up_tlast) begin
         if (m_col % 2 == 0) m_odd = 1'b1;
         if (m_first) begin
            m_ref   = m_len;
            m_first = 1'b0;
         end else if (m_len != m_ref || m_len == SAT) begin
            m_mis = 1'b1;
         end
         m_row++;
         m_col = 0;
         m_len = 0;
      end else begin
         m_col++;
      end
   endtask

   // One clock: check outputs against the model, then advance both across the rising edge.
   task automatic cycle();
      logic [10:0] o;
      int          sel;
      bit          exp_rdy, rdy_now [4];
      #1;
      for (int l = 0; l < 4; l++) begin
         o = lane_out(l);
         if (m_in_reset) begin
            chk($sformatf("reset_lane%0d", l), {21'd0, o}, 32'd0);
         end else begin
            chk($sformatf("valid_lane%0d", l), {31'd0, o[10]}, {31'd0, mq[l].size() != 0});
            if (mq[l].size() != 0)
               chk($sformatf("beat_lane%0d", l), {22'd0, o[9:0]},
                   {22'd0, mq[l][0].u, mq[l][0].l, mq[l][0].d});
         end
      end
      chk("err_odd_width", {31'd0, bus.err_odd_width}, {31'd0, m_odd});
      chk("err_len_mismatch", {31'd0, bus.err_len_mismatch}, {31'd0, m_mis});
      sel     = model_sel();
      exp_rdy = rst && (mq[sel].size() == 0 || get_rdy(sel));
      chk("up_ready", {31'd0, bus.up_ready}, {31'd0, exp_rdy});
      for (int l = 0; l < 4; l++) rdy_now[l] = get_rdy(l);
      @(posedge clk);
      if (!rst) begin
         model_reset();
         m_in_reset = 1'b1;
      end else begin
         m_in_reset = 1'b0;
         for (int l = 0; l < 4; l++)
            if (mq[l].size() != 0 && rdy_now[l]) void'(mq[l].pop_front());
         if (bus.up_valid && exp_rdy) model_accept();
      end
      @(negedge clk);
   endtask

   task automatic send(input logic [7:0] d, input logic l, input logic u);
      bus.up_valid = 1'b1;
      bus.up_data  = d;
      bus.up_tlast = l;
      bus.up_tuser = u;
      cycle();
      bus.up_valid = 1'b0;
      bus.up_tlast = 1'b0;
      bus.up_tuser = 1'b0;
   endtask

   task automatic idle(input int n);
      bus.up_valid = 1'b0;
      bus.up_tlast = 1'b0;
      bus.up_tuser = 1'b0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   vec_t tbl [8];

   initial begin
      logic [10:0] o;

      tbl[0] = '{8'h10, 1'b0, 1'b1, 0};
      tbl[1] = '{8'h11, 1'b0, 1'b0, 1};
      tbl[2] = '{8'h12, 1'b0, 1'b0, 0};
      tbl[3] = '{8'h13, 1'b1, 1'b0, 1};
      tbl[4] = '{8'h14, 1'b0, 1'b0, 2};
      tbl[5] = '{8'h15, 1'b0, 1'b0, 3};
      tbl[6] = '{8'h16, 1'b0, 1'b0, 2};
      tbl[7] = '{8'h17, 1'b1, 1'b0, 3};

      rst = 1'b0;
      bus.up_valid = 1'b0; bus.up_data = '0; bus.up_tlast = 1'b0; bus.up_tuser = 1'b0;
      set_rdy(4'hF);
      model_reset();
      @(posedge clk);
      m_in_reset = 1'b1;
      @(negedge clk);
      bus.up_valid = 1'b1;
      cycle();
      chk("reset_up_ready", {31'd0, bus.up_ready}, 32'd0);
      rst = 1'b1;
      idle(1);

      // 4x2 frame, all lanes ready
      for (int i = 0; i < 8; i++) begin
         send(tbl[i].d, tbl[i].l, tbl[i].u);
         o = lane_out(tbl[i].lane);
         chk($sformatf("tbl%0d_lane", i), {21'd0, o}, {21'd0, 1'b1, tbl[i].u, tbl[i].l, tbl[i].d});
      end
      idle(1);
      chk("frame_no_odd", {31'd0, bus.err_odd_width}, 32'd0);
      chk("frame_no_mis", {31'd0, bus.err_len_mismatch}, 32'd0);

      // lane a stalled: a,b,a
      set_rdy(4'b1110);
      send(8'h20, 1'b0, 1'b1);
      send(8'h21, 1'b0, 1'b0);
      bus.up_valid = 1'b1; bus.up_data = 8'h22;
      for (int i = 0; i < 3; i++) begin
         #1 chk("stall_up_ready", {31'd0, bus.up_ready}, 32'd0);
         cycle();
      end
      chk("stall_b_drained", {31'd0, bus.down_valid_b}, 32'd0);
      chk("stall_a_held", {24'd0, bus.down_data_a}, 32'h20);
      set_rdy(4'hF);
      #1 chk("unstall_up_ready", {31'd0, bus.up_ready}, 32'd1);
      cycle();
      bus.up_valid = 1'b0;
      chk("unstall_a", {21'd0, lane_out(0)}, {21'd0, 3'b100, 8'h22});
      idle(2);

      // widths 4 then 6
      send(8'h30, 1'b0, 1'b1);
      for (int i = 1; i < 4; i++) send(8'h30 + 8'(i), i == 3, 1'b0);
      for (int i = 0; i < 6; i++) send(8'h40 + 8'(i), i == 5, 1'b0);
      chk("mismatch_set", {31'd0, bus.err_len_mismatch}, 32'd1);
      send(8'h50, 1'b0, 1'b1);
      chk("mismatch_cleared", {31'd0, bus.err_len_mismatch}, 32'd0);
      idle(1);

      // width 3
      send(8'h60, 1'b0, 1'b1);
      send(8'h61, 1'b0, 1'b0);
      send(8'h62, 1'b1, 1'b0);
      chk("odd_width_set", {31'd0, bus.err_odd_width}, 32'd1);
      send(8'h63, 1'b0, 1'b0);
      chk("after_odd_lane_c", {21'd0, lane_out(2)}, {21'd0, 3'b100, 8'h63});

      // tuser with tlast on one pixel, then tuser mid-line at row1/col1
      send(8'h70, 1'b1, 1'b1);
      chk("tuser_tlast_a", {21'd0, lane_out(0)}, {21'd0, 3'b111, 8'h70});
      chk("tuser_tlast_odd", {31'd0, bus.err_odd_width}, 32'd1);
      send(8'h71, 1'b0, 1'b0);
      chk("row1_col0_lane_c", {21'd0, lane_out(2)}, {21'd0, 3'b100, 8'h71});
      send(8'h72, 1'b0, 1'b1);
      chk("midline_tuser_a", {21'd0, lane_out(0)}, {21'd0, 3'b110, 8'h72});
      idle(1);

      // reset with all lanes full
      set_rdy(4'h0);
      send(8'h80, 1'b0, 1'b1);
      send(8'h81, 1'b1, 1'b0);
      send(8'h82, 1'b0, 1'b0);
      send(8'h83, 1'b0, 1'b0);
      chk("all_full", {28'd0, bus.down_valid_d, bus.down_valid_c, bus.down_valid_b, bus.down_valid_a}, 32'hF);
      rst = 1'b0;
      bus.up_valid = 1'b1; bus.up_data = 8'h84;
      cycle();
      chk("rst_valids", {28'd0, bus.down_valid_d, bus.down_valid_c, bus.down_valid_b, bus.down_valid_a}, 32'h0);
      chk("rst_up_ready", {31'd0, bus.up_ready}, 32'd0);
      rst = 1'b1;
      send(8'h85, 1'b0, 1'b0);
      chk("post_rst_lane_a", {21'd0, lane_out(0)}, {21'd0, 3'b100, 8'h85});
      set_rdy(4'hF);
      idle(2);

      // saturated counter: two lines of 4095 compare as mismatch
      send(8'h00, 1'b0, 1'b1);
      for (int i = 1; i < SAT; i++) send(8'(i), i == SAT - 1, 1'b0);
      chk("sat_first_no_mis", {31'd0, bus.err_len_mismatch}, 32'd0);
      for (int i = 0; i < SAT; i++) send(8'(i), i == SAT - 1, 1'b0);
      chk("sat_second_mis", {31'd0, bus.err_len_mismatch}, 32'd1);
      idle(1);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         set_rdy({$urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0});
         bus.up_valid = $urandom_range(0, 3) != 0;
         bus.up_data  = 8'($urandom);
         bus.up_tlast = $urandom_range(0, 5) == 0;
         bus.up_tuser = $urandom_range(0, 19) == 0;
         cycle();
      end
      set_rdy(4'hF);
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
